microstep_sequencer: RTL and testbench

MICROSTEP_SEQUENCER -- requirements
Module: microstep_sequencer

---
 rtl/microstep_sequencer.sv | 153 +++++++++++++++
 tb/tb_microstep_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microstep_sequencer.sv
// Microstep phase sequencer: IDLE -> UPDATE -> SETTLE step FSM driving a wrapped phase position.
// Define STEP_COUNT_EN to add the signed step_count accumulator output.
module microstep_sequencer #(
    parameter int PHASE_STEPS = 192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              step,
    input  logic              dir,
    input  logic [2:0]        ustep_res,
    input  logic              home,
    input  logic              clr_fault,
    output logic [7:0]        pos,
    output logic              busy,
    output logic              phase_valid,
    output logic              step_done,
`ifdef STEP_COUNT_EN
    output logic              overrun,
    output logic signed [31:0] step_count
`else
    output logic              overrun
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    function automatic logic [6:0] res_to_inc(input logic [2:0] res);
        logic [2:0] r;
        r = (res > 3'd6) ? 3'd6 : res;
        return 7'd1 << r;
    endfunction

    function automatic logic [7:0] wrap_fwd(input logic [7:0] p, input logic [6:0] inc);
        logic [8:0] sum;
        sum = {1'b0, p} + {2'b00, inc};
        if (sum >= 9'(PHASE_STEPS))
            sum = sum - 9'(PHASE_STEPS);
        return sum[7:0];
    endfunction

    function automatic logic [7:0] wrap_rev(input logic [7:0] p, input logic [6:0] inc);
        logic [8:0] diff;
        if ({1'b0, p} < {2'b00, inc})
            diff = {1'b0, p} + 9'(PHASE_STEPS) - {2'b00, inc};
        else
            diff = {1'b0, p} - {2'b00, inc};
        return diff[7:0];
    endfunction

    state_t     state;
    logic       op_home;
    logic       pend;
    logic       pend_dir;
    logic       dir_r;
    logic [6:0] inc_r;
    logic       idle;
    logic       take_home;
    logic       take_pend;
    logic       take_step;
    logic       drop;
    logic       pend_load;

    assign idle        = (state == IDLE);
    assign busy        = !idle;
    assign phase_valid = idle && !pend;

    // A pending step is served ahead of a fresh one; home outranks both.
    assign take_home = idle && enable && home;
    assign take_pend = idle && enable && !home && pend;
    assign take_step = idle && enable && !home && !pend && step;
    assign drop      = enable && step && !idle && pend;
    assign pend_load = enable && step && (idle ? (pend && !home) : !pend);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pos       <= 8'd0;
            op_home   <= 1'b0;
            pend      <= 1'b0;
            step_done <= 1'b0;
            overrun   <= 1'b0;
`ifdef STEP_COUNT_EN
            step_count <= 32'sd0;
`endif
        end else begin
            step_done <= 1'b0;

            if (drop)
                overrun <= 1'b1;
            else if (clr_fault)
                overrun <= 1'b0;

            if (!enable)
                pend <= 1'b0;
            else if (idle)
                pend <= !home && pend && step;
            else if (step)
                pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (take_home || take_pend || take_step) begin
                        state   <= UPDATE;
                        op_home <= take_home;
                    end
                end
                UPDATE: begin
                    state <= SETTLE;
                    if (op_home) begin
                        pos <= 8'd0;
`ifdef STEP_COUNT_EN
                        step_count <= 32'sd0;
`endif
                    end else if (dir_r) begin
                        pos <= wrap_fwd(pos, inc_r);
`ifdef STEP_COUNT_EN
                        step_count <= step_count + $signed({25'd0, inc_r});
`endif
                    end else begin
                        pos <= wrap_rev(pos, inc_r);
`ifdef STEP_COUNT_EN
                        step_count <= step_count - $signed({25'd0, inc_r});
`endif
                    end
                end
                SETTLE: begin
                    state     <= IDLE;
                    step_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Step operands are captured at acceptance so later input changes cannot disturb the step in flight.
    always_ff @(posedge clk) begin
        if (pend_load)
            pend_dir <= dir;
        if (take_pend) begin
            dir_r <= pend_dir;
            inc_r <= res_to_inc(ustep_res);
        end else if (take_step) begin
            dir_r <= dir;
            inc_r <= res_to_inc(ustep_res);
        end
    end

endmodule

// File: tb/tb_microstep_sequencer.sv
// Self-checking bench for microstep_sequencer: directed scenarios plus randomized traffic
// compared against an abstract step/queue reference model.
module tb_microstep_sequencer;

    localparam int PS = 192;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       step;
    logic       dir;
    logic [2:0] ustep_res;
    logic       home;
    logic       clr_fault;
    logic [7:0] pos;
    logic       busy;
    logic       phase_valid;
    logic       step_done;
    logic       overrun;
`ifdef STEP_COUNT_EN
    logic signed [31:0] step_count;
`endif

    int errors = 0;
    int checks = 0;

    microstep_sequencer #(.PHASE_STEPS(PS)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .step       (step),
        .dir        (dir),
        .ustep_res  (ustep_res),
        .home       (home),
        .clr_fault  (clr_fault),
        .pos        (pos),
        .busy       (busy),
        .phase_valid(phase_valid),
        .step_done  (step_done),
`ifdef STEP_COUNT_EN
        .overrun    (overrun),
        .step_count (step_count)
`else
        .overrun    (overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an operation takes effect on pos two edges after it is accepted
    // and is reported one edge later; at most one further step may wait behind it.
    int m_pos, m_cnt, m_rem, m_inc;
    bit m_pend, m_pend_dir, m_done, m_ovr, m_home, m_dir, was_idle, was_pend;

    function automatic int inc_of(input logic [2:0] r);
        return 1 << ((r > 3'd6) ? 6 : int'(r));
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pos = 0; m_cnt = 0; m_rem = 0; m_pend = 0; m_done = 0; m_ovr = 0;
        end else begin
            was_idle = (m_rem == 0);
            was_pend = m_pend;
            m_done = (m_rem == 1);
            if (m_rem == 2) begin
                if (m_home) begin m_pos = 0; m_cnt = 0; end
                else if (m_dir) begin m_pos = (m_pos + m_inc) % PS; m_cnt = m_cnt + m_inc; end
                else begin m_pos = (m_pos + PS - m_inc) % PS; m_cnt = m_cnt - m_inc; end
            end
            if (m_rem > 0) m_rem = m_rem - 1;
            if (enable && step && !was_idle && was_pend) m_ovr = 1;
            else if (clr_fault) m_ovr = 0;
            if (!enable) m_pend = 0;
            else if (was_idle) begin
                if (home) begin
                    m_home = 1; m_rem = 2; m_pend = 0;
                end else if (was_pend) begin
                    m_home = 0; m_dir = m_pend_dir; m_inc = inc_of(ustep_res); m_rem = 2;
                    m_pend = step; m_pend_dir = dir;
                end else if (step) begin
                    m_home = 0; m_dir = dir; m_inc = inc_of(ustep_res); m_rem = 2;
                end
            end else if (step && !was_pend) begin
                m_pend = 1; m_pend_dir = dir;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one home or step request and waits (bounded) for its completion pulse.
    task automatic do_op(input logic h, input logic d, input logic [2:0] r);
        bit got;
        home = h; step = !h; dir = d; ustep_res = r;
        tick();
        home = 0; step = 0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step_done) begin got = 1; break; end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL op_timeout: step_done not seen, expected within 10 cycles"); end
        tick();
    endtask

    task automatic test_reset();
        reset = 1;
        tick();
        checks++;
        if ({pos, busy, phase_valid, step_done, overrun} !== {8'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: pos=%0d busy=%0b pv=%0b done=%0b ovr=%0b, expected 0 0 1 0 0",
                     pos, busy, phase_valid, step_done, overrun);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_basic_step();
        step = 1; dir = 1; ustep_res = 3'd0;
        tick();
        step = 0;
        checks++;
        if ({busy, phase_valid, pos} !== {1'b1, 1'b0, 8'd0}) begin
            errors++; $display("FAIL basic_accept: busy=%0b pv=%0b pos=%0d, expected 1 0 0", busy, phase_valid, pos);
        end
        tick();
        checks++;
        if ({pos, step_done} !== {8'd1, 1'b0}) begin
            errors++; $display("FAIL basic_pos: pos=%0d done=%0b, expected 1 0", pos, step_done);
        end
        tick();
        checks++;
        if ({step_done, busy, phase_valid} !== 3'b101) begin
            errors++; $display("FAIL basic_done: done=%0b busy=%0b pv=%0b, expected 1 0 1", step_done, busy, phase_valid);
        end
        tick();
        checks++;
        if (step_done !== 1'b0) begin
            errors++; $display("FAIL basic_pulse: done=%0b, expected 0", step_done);
        end
    endtask

    task automatic test_wrap();
        do_op(1, 0, 3'd0);
        do_op(0, 0, 3'd0);
        checks++;
        if (pos !== 8'd191) begin errors++; $display("FAIL wrap_rev1: pos=%0d, expected 191", pos); end
        do_op(0, 1, 3'd0);
        checks++;
        if (pos !== 8'd0) begin errors++; $display("FAIL wrap_fwd: pos=%0d, expected 0", pos); end
        do_op(0, 0, 3'd5);
        checks++;
        if (pos !== 8'd160) begin errors++; $display("FAIL wrap_rev32: pos=%0d, expected 160", pos); end
    endtask

    task automatic test_clamp();
        do_op(1, 0, 3'd0);
        do_op(0, 1, 3'd7);
        checks++;
        if (pos !== 8'd64) begin errors++; $display("FAIL clamp_one: pos=%0d, expected 64", pos); end
        do_op(0, 1, 3'd7);
        do_op(0, 1, 3'd7);
        checks++;
        if (pos !== 8'd0) begin errors++; $display("FAIL clamp_three: pos=%0d, expected 0", pos); end
    endtask

    task automatic test_overrun();
        int dones;
        do_op(1, 0, 3'd0);
        dones = 0;
        step = 1; dir = 1; ustep_res = 3'd0;
        tick(); dones += step_done;
        tick(); dones += step_done;
        clr_fault = 1;
        tick(); dones += step_done;
        step = 0; clr_fault = 0;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: overrun=%0b, expected 1", overrun); end
        for (int i = 0; i < 10; i++) begin tick(); dones += step_done; end
        checks++;
        if (dones != 2) begin errors++; $display("FAIL overrun_dones: step_done pulses=%0d, expected 2", dones); end
        checks++;
        if (pos !== 8'd2) begin errors++; $display("FAIL overrun_pos: pos=%0d, expected 2", pos); end
        clr_fault = 1;
        tick();
        clr_fault = 0;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr: overrun=%0b, expected 0", overrun); end
    endtask

    task automatic test_home_priority();
        int dones;
        do_op(1, 0, 3'd0);
        do_op(0, 1, 3'd6);
        do_op(0, 1, 3'd5);
        do_op(0, 1, 3'd2);
        checks++;
        if (pos !== 8'd100) begin errors++; $display("FAIL home_setup: pos=%0d, expected 100", pos); end
        home = 1; step = 1; dir = 1; ustep_res = 3'd0;
        tick();
        home = 0; step = 0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin tick(); dones += step_done; end
        checks++;
        if (pos !== 8'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL home_pos: pos=%0d busy=%0b, expected 0 0", pos, busy);
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL home_dones: step_done pulses=%0d, expected 1", dones); end
    endtask

    task automatic test_enable();
        int dones;
        do_op(1, 0, 3'd0);
        enable = 0; step = 1; dir = 1; ustep_res = 3'd0;
        tick();
        step = 0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (pos !== 8'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL enable_ignore: pos=%0d busy=%0b, expected 0 0", pos, busy);
        end
        enable = 1; step = 1;
        tick();
        tick();
        step = 0; enable = 0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin tick(); dones += step_done; end
        enable = 1;
        checks++;
        if (pos !== 8'd1 || dones != 1) begin
            errors++; $display("FAIL enable_flush: pos=%0d dones=%0d, expected 1 1", pos, dones);
        end
    endtask

    task automatic test_reset_midstep();
        int dones;
        do_op(1, 0, 3'd0);
        do_op(0, 1, 3'd0);
        step = 1; dir = 1; ustep_res = 3'd0;
        tick();
        step = 0;
        #1 reset = 1;
        #1;
        checks++;
        if ({pos, busy, phase_valid, step_done} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_async: pos=%0d busy=%0b pv=%0b done=%0b, expected 0 0 1 0",
                               pos, busy, phase_valid, step_done);
        end
        #2 reset = 0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin tick(); dones += step_done; end
        checks++;
        if (dones != 0 || pos !== 8'd0) begin
            errors++; $display("FAIL reset_abort: dones=%0d pos=%0d, expected 0 0", dones, pos);
        end
    endtask

`ifdef STEP_COUNT_EN
    task automatic test_step_count();
        do_op(1, 0, 3'd0);
        for (int i = 0; i < 4; i++) do_op(0, 1, 3'd2);
        do_op(0, 0, 3'd2);
        checks++;
        if (step_count !== 32'sd12) begin errors++; $display("FAIL step_count: got %0d, expected 12", step_count); end
        do_op(0, 0, 3'd6);
        checks++;
        if (step_count !== -32'sd52) begin errors++; $display("FAIL step_count_neg: got %0d, expected -52", step_count); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            enable    = ($urandom_range(0, 15) != 0);
            step      = ($urandom_range(0, 2) == 0);
            dir       = 1'($urandom_range(0, 1));
            ustep_res = 3'($urandom_range(0, 7));
            home      = ($urandom_range(0, 24) == 0);
            clr_fault = ($urandom_range(0, 9) == 0);
            tick();
            checks++;
            if (pos !== 8'(m_pos)) begin errors++; $display("FAIL rnd_pos cyc %0d: got %0d, expected %0d", i, pos, m_pos); end
            checks++;
            if (busy !== (m_rem != 0)) begin errors++; $display("FAIL rnd_busy cyc %0d: got %0b, expected %0b", i, busy, m_rem != 0); end
            checks++;
            if (phase_valid !== (m_rem == 0 && !m_pend)) begin
                errors++; $display("FAIL rnd_pv cyc %0d: got %0b, expected %0b", i, phase_valid, m_rem == 0 && !m_pend);
            end
            checks++;
            if (step_done !== m_done) begin errors++; $display("FAIL rnd_done cyc %0d: got %0b, expected %0b", i, step_done, m_done); end
            checks++;
            if (overrun !== m_ovr) begin errors++; $display("FAIL rnd_ovr cyc %0d: got %0b, expected %0b", i, overrun, m_ovr); end
`ifdef STEP_COUNT_EN
            checks++;
            if (step_count !== 32'(m_cnt)) begin errors++; $display("FAIL rnd_cnt cyc %0d: got %0d, expected %0d", i, step_count, m_cnt); end
`endif
        end
        step = 0; home = 0; clr_fault = 0; enable = 1;
    endtask

    initial begin
        reset = 1; enable = 1; step = 0; dir = 0; ustep_res = 3'd0; home = 0; clr_fault = 0;
        test_reset();
        test_basic_step();
        test_wrap();
        test_clamp();
        test_overrun();
        test_home_priority();
        test_enable();
        test_reset_midstep();
`ifdef STEP_COUNT_EN
        test_step_count();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
